// File: rtl/uart_row_packet_engine_pkg.sv
// Shared FSM state type and default protocol byte codes for the UART row-packet engine.
package uart2vga_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ROW  = 3'd1,
        DATA = 3'd2,
        STOP = 3'd3,
        SKIP = 3'd4
    } state_t;

    localparam logic [7:0] CODE_STOP      = 8'hDD;
    localparam logic [7:0] CODE_ACK_ROW   = 8'hCC;
    localparam logic [7:0] CODE_ACK_DATA  = 8'hAA;
    localparam logic [7:0] CODE_ACK_OK    = 8'hFF;
    localparam logic [7:0] CODE_NAK_SHORT = 8'h11;
    localparam logic [7:0] CODE_NAK_ERR   = 8'hEE;

endpackage

// File: rtl/uart_row_packet_engine_if.sv
// Bundles the receiver, transmitter and framebuffer-side signals of the row-packet engine.
// The slave modport is the engine; the master modport is whatever drives and observes it.
interface uart_row_packet_engine_if #(
    parameter int ADDR_W  = 17,
    parameter int Y_BYTES = 2
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 tx_busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [7:0]           wr_data;
    logic                 row_done;
    logic [8*Y_BYTES-1:0] row_y;
    logic                 busy;
    logic                 err_ovf;

    modport slave (
        input  rx_data, rx_valid, tx_busy,
        output tx_start, tx_data, wr_en, wr_addr, wr_data, row_done, row_y, busy, err_ovf
    );

    modport master (
        output rx_data, rx_valid, tx_busy,
        input  tx_start, tx_data, wr_en, wr_addr, wr_data, row_done, row_y, busy, err_ovf
    );
endinterface

// File: rtl/uart_row_packet_engine_ans_fifo.sv
// Answer byte FIFO: one or two writes per cycle, one read per cycle, count output.
// Latency 1 cycle write-to-visible; caller checks space, pops on an empty FIFO are ignored.
module ans_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_push2,
    input  logic [7:0]             i_dat0,
    input  logic [7:0]             i_dat1,
    input  logic                   i_pop,
    output logic [7:0]             o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_wptr1;
    logic [1:0]    w_nwr;
    logic          w_pop;

    assign w_wptr1 = r_wptr + 1'b1;
    assign w_nwr   = !i_push ? 2'd0 : (i_push2 ? 2'd2 : 2'd1);
    assign w_pop   = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_dat0;
        end
        if (i_push && i_push2) begin
            r_mem[w_wptr1] <= i_dat1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_nwr);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_nwr) - (AW+1)'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

// File: rtl/uart_row_packet_engine.sv
// Parses [Y][payload][STOP] packets from the UART, writes rows to the framebuffer, queues answers.
// Answer push 1 cycle after rx_valid, tx_start >=1 cycle later; tx_busy stalls the answer FIFO, overflow drops bytes.
module uart_row_packet_engine
    import uart2vga_pkg::*;
#(
    parameter int         ROW_BYTES   = 240,
    parameter int         Y_BYTES     = 2,
    parameter int         ROW_COUNT   = 480,
    parameter logic [7:0] STOP_BYTE   = CODE_STOP,
    parameter logic [7:0] ACK_ROW     = CODE_ACK_ROW,
    parameter logic [7:0] ACK_DATA    = CODE_ACK_DATA,
    parameter logic [7:0] ACK_OK      = CODE_ACK_OK,
    parameter logic [7:0] NAK_SHORT   = CODE_NAK_SHORT,
    parameter logic [7:0] NAK_ERR     = CODE_NAK_ERR,
    parameter int         TIMEOUT_CYC = 500_000,
    parameter int         ANS_DEPTH   = 4,
    parameter int         ADDR_W      = $clog2(ROW_COUNT * ROW_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_row_packet_engine_if.slave bus
);
    localparam int IDX_W = $clog2(ROW_BYTES + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam int YW    = 8 * Y_BYTES;
    localparam int CNT_W = $clog2(ANS_DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [YW-1:0]     r_y;
    logic [YW-1:0]     w_y_nxt;
    logic [2:0]        r_yidx;
    logic [IDX_W-1:0]  r_idx;
    logic [TMO_W-1:0]  r_tmo;
    logic              w_tmo_exp;
    logic              w_y_last;
    logic              w_y_ok;
    logic              w_push;
    logic              w_pair;
    logic [7:0]        w_push_dat;
    logic              w_wr;
    logic              w_done;
    logic [31:0]       w_rcvd;
    logic [31:0]       w_miss;
    logic [7:0]        w_miss_sat;
    logic [ADDR_W-1:0] w_wr_addr;

    logic              r_push_vld;
    logic              r_push_pair;
    logic [7:0]        r_push_dat0;
    logic [7:0]        r_push_dat1;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_row_done;
    logic              r_err_ovf;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_free;
    logic [7:0]        w_head;
    logic              w_full;
    logic              w_pop;
    logic              w_fifo_push;
    logic              w_drop;

    assign w_tmo_exp = (r_state != IDLE) && !bus.rx_valid && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign w_y_last  = (r_state == IDLE) ? (Y_BYTES == 1) : (r_yidx == 3'(Y_BYTES - 1));
    assign w_y_ok    = {1'b0, w_y_nxt} < (YW+1)'(ROW_COUNT);
    assign w_wr_addr = ADDR_W'(r_y) * ADDR_W'(ROW_BYTES) + ADDR_W'(r_idx);

    // Only payload and terminator count towards the missing-byte report.
    always_comb begin
        w_rcvd = 32'd0;
        if (r_state == DATA) begin
            w_rcvd = 32'(r_idx);
        end else if (r_state == STOP) begin
            w_rcvd = 32'(ROW_BYTES);
        end
        w_miss     = 32'(ROW_BYTES + 1) - w_rcvd;
        w_miss_sat = (w_miss > 32'd255) ? 8'hFF : w_miss[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pair      = 1'b0;
        w_push_dat  = ACK_ROW;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        w_y_nxt     = r_y;
        if (r_state == IDLE) begin
            w_y_nxt = YW'(bus.rx_data);
        end else begin
            w_y_nxt[8*r_yidx +: 8] = bus.rx_data;
        end

        if (bus.rx_valid) begin
            case (r_state)
                IDLE, ROW: begin
                    w_push = 1'b1;
                    if (!w_y_last) begin
                        w_state_nxt = ROW;
                    end else if (w_y_ok) begin
                        w_state_nxt = DATA;
                    end else begin
                        w_push_dat  = NAK_ERR;
                        w_state_nxt = SKIP;
                    end
                end
                DATA: begin
                    w_push     = 1'b1;
                    w_push_dat = ACK_DATA;
                    w_wr       = 1'b1;
                    if (r_idx == IDX_W'(ROW_BYTES - 1)) begin
                        w_state_nxt = STOP;
                    end
                end
                STOP: begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                    if (bus.rx_data == STOP_BYTE) begin
                        w_push_dat = ACK_OK;
                        w_done     = 1'b1;
                    end else begin
                        w_push_dat = NAK_ERR;
                    end
                end
                SKIP: begin
                    if (r_idx == IDX_W'(ROW_BYTES)) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end else if (w_tmo_exp) begin
            w_state_nxt = IDLE;
            if (r_state != SKIP) begin
                w_pair     = 1'b1;
                w_push_dat = NAK_SHORT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_yidx      <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_push_vld  <= 1'b0;
            r_push_pair <= 1'b0;
            r_push_dat0 <= '0;
            r_push_dat1 <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_row_done  <= 1'b0;
        end else begin
            r_push_vld  <= w_push | w_pair;
            r_push_pair <= w_pair;
            r_push_dat0 <= w_push_dat;
            r_push_dat1 <= w_miss_sat;
            r_wr_en     <= w_wr;
            r_row_done  <= w_done;
            if (w_wr) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= bus.rx_data;
            end
            if (bus.rx_valid && (r_state == IDLE || r_state == ROW)) begin
                r_y    <= w_y_nxt;
                r_yidx <= (r_state == IDLE) ? 3'd1 : r_yidx + 3'd1;
            end
            if (w_state_nxt != r_state) begin
                r_idx <= '0;
            end else if (bus.rx_valid && (r_state == DATA || r_state == SKIP)) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == IDLE || bus.rx_valid || w_tmo_exp) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // The timeout pair is pushed atomically so the missing count never lands without its header.
    assign w_full      = (w_count == CNT_W'(ANS_DEPTH));
    assign w_free      = CNT_W'(ANS_DEPTH) - w_count;
    assign w_fifo_push = r_push_vld && (r_push_pair ? (w_free >= CNT_W'(2)) : !w_full);
    assign w_drop      = r_push_vld && !w_fifo_push;
    assign w_pop       = (w_count != '0) && !bus.tx_busy && !r_tx_start;

    ans_fifo #(
        .DEPTH (ANS_DEPTH)
    ) u_ans_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_push2 (r_push_pair),
        .i_dat0  (r_push_dat0),
        .i_dat1  (r_push_dat1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= w_head;
            end
            if (w_drop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.row_done = r_row_done;
    assign bus.row_y    = r_y;
    assign bus.busy     = (r_state != IDLE);
    assign bus.err_ovf  = r_err_ovf;
endmodule

// File: tb/tb_uart_row_packet_engine.sv
// Scoreboard bench for uart_row_packet_engine: byte-level rx strobes, modelled transmitter busy.
module tb_uart_row_packet_engine;
    localparam int ROW_BYTES   = 240;
    localparam int Y_BYTES     = 2;
    localparam int ROW_COUNT   = 480;
    localparam int TIMEOUT_CYC = 100;
    localparam int ANS_DEPTH   = 4;
    localparam int ADDR_W      = $clog2(ROW_COUNT * ROW_BYTES);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_row_packet_engine_if #(.ADDR_W(ADDR_W), .Y_BYTES(Y_BYTES)) bus ();

    uart_row_packet_engine #(
        .ROW_BYTES   (ROW_BYTES),
        .Y_BYTES     (Y_BYTES),
        .ROW_COUNT   (ROW_COUNT),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .ANS_DEPTH   (ANS_DEPTH),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          n_unexp_ans = 0;
    int          n_unexp_wr = 0;
    int          n_b2b = 0;
    int          n_unstable = 0;
    int          n_done = 0;
    int          exp_done = 0;
    logic [7:0]  exp_ans[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_dat[$];
    logic [7:0]  m_exp8;
    logic [31:0] m_exp32;
    logic        prev_start = 1'b0;
    logic [7:0]  last_tx = 8'h00;
    bit          hold_busy = 1'b0;
    int          busy_left = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4000; i++) begin
            if (exp_ans.size() == 0 && exp_addr.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("drain_pending", exp_ans.size(), 0);
    endtask

    task automatic send_row(input int y, input logic [7:0] term, input bit dd_ends);
        logic [7:0] p;
        logic [7:0] yb;
        exp_ans.push_back(8'hCC);
        exp_ans.push_back(8'hCC);
        yb = y[7:0];
        send(yb);
        yb = y[15:8];
        send(yb);
        for (int i = 0; i < ROW_BYTES; i++) begin
            p = 8'($urandom);
            if (dd_ends && (i == 0 || i == ROW_BYTES - 1)) p = 8'hDD;
            exp_ans.push_back(8'hAA);
            exp_addr.push_back(32'(y * ROW_BYTES + i));
            exp_dat.push_back(p);
            send(p);
        end
        if (term == 8'hDD) begin
            exp_ans.push_back(8'hFF);
            exp_done++;
        end else begin
            exp_ans.push_back(8'hEE);
        end
        send(term);
        wait_drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_start"}, bus.tx_start, 0);
        chk({tag, "_tx_data"},  bus.tx_data, 0);
        chk({tag, "_wr_en"},    bus.wr_en, 0);
        chk({tag, "_wr_addr"},  bus.wr_addr, 0);
        chk({tag, "_wr_data"},  bus.wr_data, 0);
        chk({tag, "_row_done"}, bus.row_done, 0);
        chk({tag, "_row_y"},    bus.row_y, 0);
        chk({tag, "_busy"},     bus.busy, 0);
        chk({tag, "_err_ovf"},  bus.err_ovf, 0);
    endtask

    // Transmitter model: busy for three cycles after each start, or while held.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.tx_start) busy_left = 3;
            else if (busy_left > 0) busy_left--;
            bus.tx_busy = hold_busy || (busy_left != 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (bus.tx_start) begin
                if (prev_start) n_b2b++;
                last_tx = bus.tx_data;
                if (exp_ans.size() != 0) begin
                    m_exp8 = exp_ans.pop_front();
                    chk("answer", bus.tx_data, m_exp8);
                end else begin
                    n_unexp_ans++;
                end
            end else if (bus.tx_busy && bus.tx_data !== last_tx) begin
                n_unstable++;
            end
            prev_start = bus.tx_start;
            if (bus.wr_en) begin
                if (exp_addr.size() != 0) begin
                    m_exp32 = exp_addr.pop_front();
                    chk("wr_addr", bus.wr_addr, m_exp32);
                    m_exp8 = exp_dat.pop_front();
                    chk("wr_data", bus.wr_data, m_exp8);
                end else begin
                    n_unexp_wr++;
                end
            end
            if (bus.row_done) n_done++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Good row 257: addresses 61680..61919.
        send_row(257, 8'hDD, 1'b0);
        chk("t1_row_done", n_done, exp_done);
        chk("t1_row_y", bus.row_y, 257);
        chk("t1_busy", bus.busy, 0);

        // Row 480 is out of range: CC then EE, then 241 silent bytes.
        exp_ans.push_back(8'hCC);
        exp_ans.push_back(8'hEE);
        send(8'hE0);
        send(8'h01);
        chk("t2_busy_skip", bus.busy, 1);
        for (int i = 0; i < ROW_BYTES + 1; i++) begin
            p = (i % 7 == 0) ? 8'hDD : 8'($urandom);
            send(p);
        end
        wait_drain();
        chk("t2_busy_idle", bus.busy, 0);
        chk("t2_row_y", bus.row_y, 480);
        chk("t2_unexp_ans", n_unexp_ans, 0);
        chk("t2_unexp_wr", n_unexp_wr, 0);

        // Short packet: 100 payload bytes then silence -> 11, 8D.
        exp_ans.push_back(8'hCC);
        exp_ans.push_back(8'hCC);
        send(8'h05);
        send(8'h00);
        for (int i = 0; i < 100; i++) begin
            p = 8'($urandom);
            exp_ans.push_back(8'hAA);
            exp_addr.push_back(32'(5 * ROW_BYTES + i));
            exp_dat.push_back(p);
            send(p);
        end
        exp_ans.push_back(8'h11);
        exp_ans.push_back(8'h8D);
        repeat (TIMEOUT_CYC + 50) @(posedge clk);
        wait_drain();
        chk("t3_busy", bus.busy, 0);
        chk("t3_row_done", n_done, exp_done);

        // Timeout after a single Y byte: nothing received, 241 missing.
        exp_ans.push_back(8'hCC);
        exp_ans.push_back(8'h11);
        exp_ans.push_back(8'hF1);
        send(8'h07);
        repeat (TIMEOUT_CYC + 50) @(posedge clk);
        wait_drain();
        chk("t3b_busy", bus.busy, 0);

        // Bad terminator.
        send_row(2, 8'h00, 1'b0);
        chk("t4_row_done", n_done, exp_done);

        // Last valid row, DD inside payload at both ends.
        send_row(ROW_COUNT - 1, 8'hDD, 1'b1);
        chk("t5_row_done", n_done, exp_done);
        chk("t5_row_y", bus.row_y, ROW_COUNT - 1);

        // Overflow with transmitter stalled, then a mid-packet reset.
        chk("t6_ovf_init", bus.err_ovf, 0);
        hold_busy = 1'b1;
        repeat (4) @(posedge clk);
        exp_ans.push_back(8'hCC);
        exp_ans.push_back(8'hCC);
        exp_ans.push_back(8'hAA);
        exp_ans.push_back(8'hAA);
        send(8'h03);
        send(8'h00);
        for (int i = 0; i < 4; i++) begin
            p = 8'($urandom);
            exp_addr.push_back(32'(3 * ROW_BYTES + i));
            exp_dat.push_back(p);
            send(p);
            if (i == 1) chk("t6_ovf_at_full", bus.err_ovf, 0);
            if (i == 2) chk("t6_ovf_set", bus.err_ovf, 1);
        end
        hold_busy = 1'b0;
        wait_drain();
        chk("t6_ovf_sticky", bus.err_ovf, 1);
        hold_busy = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 4; i < 6; i++) begin
            p = 8'($urandom);
            exp_addr.push_back(32'(3 * ROW_BYTES + i));
            exp_dat.push_back(p);
            send(p);
        end
        chk("t6_busy_mid", bus.busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        last_tx = 8'h00;
        exp_ans.delete();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("t6_rst");
        hold_busy = 1'b0;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        chk("t6_stale_tx", n_unexp_ans, 0);
        chk("t6_busy_after", bus.busy, 0);
        chk("t6_row_done", n_done, exp_done);

        chk("unexp_wr_total", n_unexp_wr, 0);
        chk("tx_start_b2b", n_b2b, 0);
        chk("tx_data_unstable", n_unstable, 0);
        chk("wr_pending", exp_addr.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
